// File: rtl/mips_iter_divider_pkg.sv
// rtl/mips_iter_divider_pkg.sv - shared definitions for the iterative divider
//
// Contents:
//   DIV_DEFAULT_W  default operand width
//   div_state_t    divider FSM state encoding
//   div_cnt_w()    width of the step counter for a given operand width
package mips_iter_divider_pkg;

  localparam int DIV_DEFAULT_W = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Counter must index steps 0..w-1; never narrower than one bit.
  function automatic int div_cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/mips_iter_divider_div_step.sv
// rtl/mips_iter_divider_div_step.sv - one combinational restoring-division step
//
// Ports:
//   r        current partial remainder (always < divisor between steps)
//   q_msb    next dividend bit shifted into the remainder
//   divisor  divisor magnitude
//   r_next   partial remainder after this step
//   q_bit    quotient bit produced by this step
module mips_iter_divider_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] r,
  input  logic              q_msb,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] r_next,
  output logic              q_bit
);

  // The trial value needs one extra bit: r can be up to divisor-1, so
  // {r, q_msb} may exceed DATA_W bits before the subtraction.
  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] diff;

  assign trial  = {r, q_msb};
  assign q_bit  = (trial >= {1'b0, divisor});
  // When the subtraction succeeds the result is < divisor, so the low
  // DATA_W bits of the modular difference are exact.
  assign diff   = trial[DATA_W-1:0] - divisor;
  assign r_next = q_bit ? diff : trial[DATA_W-1:0];

endmodule

// File: rtl/mips_iter_divider.sv
// rtl/mips_iter_divider.sv - multi-cycle restoring divider for MIPS DIV/DIVU
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   cancel               pipeline flush; drops any operation in flight
//   s_axis_dividend_*    dividend operand channel (tdata/tvalid/tready)
//   s_axis_divisor_*     divisor operand channel (tdata/tvalid/tready)
//   m_axis_dout_tdata    {quotient, remainder}, held until the next result
//   m_axis_dout_tvalid   one-cycle result pulse, no back-pressure
//   busy                 an operand is held or a division is running
module mips_iter_divider
  import mips_iter_divider_pkg::*;
#(
  parameter int DATA_W = DIV_DEFAULT_W,
  parameter bit SIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cancel,
  input  logic [DATA_W-1:0]     s_axis_dividend_tdata,
  input  logic                  s_axis_dividend_tvalid,
  output logic                  s_axis_dividend_tready,
  input  logic [DATA_W-1:0]     s_axis_divisor_tdata,
  input  logic                  s_axis_divisor_tvalid,
  output logic                  s_axis_divisor_tready,
  output logic [2*DATA_W-1:0]   m_axis_dout_tdata,
  output logic                  m_axis_dout_tvalid,
  output logic                  busy
);

  localparam int               CNT_W    = div_cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  div_state_t          state;
  logic                ready_en;   // low in reset, high from the first edge after
  logic                dvd_full;
  logic                dvs_full;
  logic [DATA_W-1:0]   dvd_slot;
  logic [DATA_W-1:0]   dvs_slot;
  logic [DATA_W-1:0]   rem;        // partial remainder
  logic [DATA_W-1:0]   quo;        // dividend bits shift out, quotient bits shift in
  logic [DATA_W-1:0]   dvs_mag;
  logic [CNT_W-1:0]    cnt;
  logic                sign_q;
  logic                sign_r;
  logic [2*DATA_W-1:0] dout;

  logic                accept_open;
  logic                hs_dvd;
  logic                hs_dvs;
  logic                both_ready;
  logic [DATA_W-1:0]   dvd_now;
  logic [DATA_W-1:0]   dvs_now;
  logic                dvd_neg;
  logic                dvs_neg;
  logic [DATA_W-1:0]   dvd_mag_now;
  logic [DATA_W-1:0]   dvs_mag_now;
  logic [DATA_W-1:0]   step_r;
  logic                step_q;
  logic [DATA_W-1:0]   q_last;
  logic [DATA_W-1:0]   q_out;
  logic [DATA_W-1:0]   r_out;

  // Operand acceptance
  assign accept_open            = ready_en & (state == DIV_IDLE) & ~cancel;
  assign s_axis_dividend_tready = accept_open & ~dvd_full;
  assign s_axis_divisor_tready  = accept_open & ~dvs_full;

  assign hs_dvd = s_axis_dividend_tvalid & s_axis_dividend_tready;
  assign hs_dvs = s_axis_divisor_tvalid & s_axis_divisor_tready;

  // An operand arriving on the same edge as the other slot filling still
  // starts the division, so take it straight from the bus in that case.
  assign both_ready = (dvd_full | hs_dvd) & (dvs_full | hs_dvs);
  assign dvd_now    = dvd_full ? dvd_slot : s_axis_dividend_tdata;
  assign dvs_now    = dvs_full ? dvs_slot : s_axis_divisor_tdata;

  // Magnitudes; -(most negative) wraps to itself, which is the correct
  // unsigned magnitude.
  assign dvd_neg     = SIGNED && dvd_now[DATA_W-1];
  assign dvs_neg     = SIGNED && dvs_now[DATA_W-1];
  assign dvd_mag_now = dvd_neg ? (~dvd_now + 1'b1) : dvd_now;
  assign dvs_mag_now = dvs_neg ? (~dvs_now + 1'b1) : dvs_now;

  mips_iter_divider_div_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .r       (rem),
    .q_msb   (quo[DATA_W-1]),
    .divisor (dvs_mag),
    .r_next  (step_r),
    .q_bit   (step_q)
  );

  // Final quotient/remainder as they will look after the last step.
  always_comb begin
    q_last = {quo[DATA_W-2:0], step_q};
    q_out  = sign_q ? (~q_last + 1'b1) : q_last;
    r_out  = sign_r ? (~step_r + 1'b1) : step_r;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= DIV_IDLE;
      ready_en <= 1'b0;
      dvd_full <= 1'b0;
      dvs_full <= 1'b0;
      dvd_slot <= '0;
      dvs_slot <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs_mag  <= '0;
      cnt      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      dout     <= '0;
    end else begin
      ready_en <= 1'b1;
      if (cancel) begin
        state    <= DIV_IDLE;
        dvd_full <= 1'b0;
        dvs_full <= 1'b0;
        cnt      <= '0;
      end else begin
        case (state)
          DIV_IDLE: begin
            if (hs_dvd) begin
              dvd_slot <= s_axis_dividend_tdata;
              dvd_full <= 1'b1;
            end
            if (hs_dvs) begin
              dvs_slot <= s_axis_divisor_tdata;
              dvs_full <= 1'b1;
            end
            if (both_ready) begin
              state   <= DIV_CALC;
              sign_q  <= dvd_neg ^ dvs_neg;
              sign_r  <= dvd_neg;
              rem     <= '0;
              quo     <= dvd_mag_now;
              dvs_mag <= dvs_mag_now;
              cnt     <= '0;
            end
          end
          DIV_CALC: begin
            rem <= step_r;
            quo <= q_last;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state <= DIV_DONE;
              dout  <= {q_out, r_out};
            end
          end
          DIV_DONE: begin
            dvd_full <= 1'b0;
            dvs_full <= 1'b0;
            state    <= DIV_IDLE;
          end
          default: state <= DIV_IDLE;
        endcase
      end
    end
  end

  // A flush landing in the result cycle must still kill the pulse.
  assign m_axis_dout_tvalid = (state == DIV_DONE) & ~cancel;
  assign m_axis_dout_tdata  = dout;
  assign busy               = (state != DIV_IDLE) | dvd_full | dvs_full;

endmodule

// File: tb/tb_mips_iter_divider.sv
// tb/tb_mips_iter_divider.sv - self-checking bench for mips_iter_divider
module tb_mips_iter_divider;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cancel = 1'b0;
  logic [31:0] dvd_data = '0;
  logic [31:0] dvs_data = '0;
  logic        dvd_valid = 1'b0;
  logic        dvs_valid = 1'b0;

  logic        dvd_ready_s, dvs_ready_s, dvalid_s, busy_s;
  logic [63:0] dout_s;
  logic        dvd_ready_u, dvs_ready_u, dvalid_u, busy_u;
  logic [63:0] dout_u;

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Both instances see identical stimulus and run in lockstep.
  mips_iter_divider #(.DATA_W(32), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .resetn(resetn), .cancel(cancel),
    .s_axis_dividend_tdata(dvd_data), .s_axis_dividend_tvalid(dvd_valid),
    .s_axis_dividend_tready(dvd_ready_s),
    .s_axis_divisor_tdata(dvs_data), .s_axis_divisor_tvalid(dvs_valid),
    .s_axis_divisor_tready(dvs_ready_s),
    .m_axis_dout_tdata(dout_s), .m_axis_dout_tvalid(dvalid_s), .busy(busy_s)
  );

  mips_iter_divider #(.DATA_W(32), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .resetn(resetn), .cancel(cancel),
    .s_axis_dividend_tdata(dvd_data), .s_axis_dividend_tvalid(dvd_valid),
    .s_axis_dividend_tready(dvd_ready_u),
    .s_axis_divisor_tdata(dvs_data), .s_axis_divisor_tvalid(dvs_valid),
    .s_axis_divisor_tready(dvs_ready_u),
    .m_axis_dout_tdata(dout_u), .m_axis_dout_tvalid(dvalid_u), .busy(busy_u)
  );

  // Reference: MIPS division rules in plain integer arithmetic.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    int sa, sb;
    if (!sgn) return (b == 0) ? {32'hFFFF_FFFF, a} : {a / b, a % b};
    if (b == 0) return {(a[31] ? 32'd1 : 32'hFFFF_FFFF), a};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
    sa = a;
    sb = b;
    return {32'(sa / sb), 32'(sa % sb)};
  endfunction

  function automatic logic [31:0] rand_operand(input bit is_divisor);
    case ($urandom_range(0, 7))
      0:       return is_divisor ? 32'd0 : 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 20));
      3:       return 32'(0 - $urandom_range(1, 20));
      4:       return 32'($urandom_range(0, 65535));
      default: return 32'($urandom);
    endcase
  endfunction

  // Presents both operands and returns after the accepting edge.
  task automatic accept_both(input logic [31:0] a, input logic [31:0] b, output int acc_edge);
    int guard;
    guard = 0;
    dvd_data = a; dvs_data = b; dvd_valid = 1'b1; dvs_valid = 1'b1;
    #1;
    while (!(dvd_ready_s && dvs_ready_s && dvd_ready_u && dvs_ready_u) && guard < 100) begin
      @(negedge clk); #1;
      guard++;
    end
    checks++;
    if (guard >= 100) begin
      errors++;
      $display("FAIL accept_timeout: ready s=%b%b u=%b%b want all 1", dvd_ready_s, dvs_ready_s, dvd_ready_u, dvs_ready_u);
    end
    @(posedge clk); #1;
    acc_edge = edge_cnt;
  endtask

  // Waits for the result pulse; reports edges since acceptance and pulse shape.
  task automatic collect(output bit found, output int lat, output logic [63:0] ds,
                         output logic [63:0] du, output bit both, output bit one);
    found = 0; lat = 0; ds = '0; du = '0; both = 0; one = 0;
    for (int n = 1; n <= 60 && !found; n++) begin
      @(posedge clk); #1;
      if (dvalid_s || dvalid_u) begin
        found = 1; lat = n; ds = dout_s; du = dout_u;
        both = dvalid_s && dvalid_u;
        @(posedge clk); #1;
        one = !dvalid_s && !dvalid_u;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({dvd_ready_s, dvs_ready_s, dvalid_s, busy_s, dvd_ready_u, dvs_ready_u, dvalid_u, busy_u} !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000000",
        {dvd_ready_s, dvs_ready_s, dvalid_s, busy_s, dvd_ready_u, dvs_ready_u, dvalid_u, busy_u});
    end
    checks++;
    if (dout_s !== 64'h0 || dout_u !== 64'h0) begin
      errors++; $display("FAIL reset_tdata: got %h/%h want 0", dout_s, dout_u);
    end
    @(negedge clk); resetn = 1'b1; #1;
    checks++;
    if (dvd_ready_s !== 1'b0 || dvs_ready_s !== 1'b0) begin
      errors++; $display("FAIL reset_release_ready: got %b%b want 00 before first edge", dvd_ready_s, dvs_ready_s);
    end
    @(posedge clk); #1;
    checks++;
    if ({dvd_ready_s, dvs_ready_s, dvd_ready_u, dvs_ready_u} !== 4'hF) begin
      errors++; $display("FAIL reset_first_edge_ready: got %b want 1111", {dvd_ready_s, dvs_ready_s, dvd_ready_u, dvs_ready_u});
    end
  endtask

  task automatic test_unsigned_basic();
    int e, lat; bit f, both, one; logic [63:0] ds, du;
    accept_both(32'd100, 32'd7, e);
    dvd_valid = 1'b0; dvs_valid = 1'b0;
    collect(f, lat, ds, du, both, one);
    checks++;
    if (!f || lat != 32) begin errors++; $display("FAIL basic_latency: got %0d edges (found=%0b) want 32", lat, f); end
    checks++;
    if (du !== 64'h0000000E_00000002) begin errors++; $display("FAIL basic_udata: got %h want 0000000e00000002", du); end
    checks++;
    if (ds !== 64'h0000000E_00000002) begin errors++; $display("FAIL basic_sdata: got %h want 0000000e00000002", ds); end
    checks++;
    if (!both || !one) begin errors++; $display("FAIL basic_pulse: got both=%0b one=%0b want 1 1", both, one); end
  endtask

  task automatic test_staggered();
    int lat; bit f, both, one; logic [63:0] ds, du;
    @(negedge clk);
    dvd_data = 32'hFFFF_FFF9; dvd_valid = 1'b1;
    @(posedge clk); #1;
    dvd_data = 32'h1234_5678;  // must not overwrite the held dividend
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dvd_ready_s !== 1'b0 || dvs_ready_s !== 1'b1 || busy_s !== 1'b1) begin
        errors++; $display("FAIL stagger_hold_%0d: got dvd_rdy=%b dvs_rdy=%b busy=%b want 0 1 1", i, dvd_ready_s, dvs_ready_s, busy_s);
      end
      if (i < 2) begin @(posedge clk); #1; end
    end
    dvs_data = 32'd2; dvs_valid = 1'b1;
    @(posedge clk); #1;
    dvd_valid = 1'b0; dvs_valid = 1'b0;
    collect(f, lat, ds, du, both, one);
    checks++;
    if (!f || lat != 32) begin errors++; $display("FAIL stagger_latency: got %0d edges (found=%0b) want 32", lat, f); end
    checks++;
    if (ds !== 64'hFFFFFFFD_FFFFFFFF) begin errors++; $display("FAIL stagger_sdata: got %h want fffffffdffffffff", ds); end
    checks++;
    if (du !== 64'h7FFFFFFC_00000001) begin errors++; $display("FAIL stagger_udata: got %h want 7ffffffc00000001", du); end
  endtask

  task automatic test_corners();
    logic [31:0] ta [5] = '{32'h8000_0000, 32'd5, 32'hFFFF_FFFB, 32'h8000_0000, 32'd7};
    logic [31:0] tb [5] = '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'd1, 32'hFFFF_FFFE};
    logic [63:0] es [5] = '{64'h80000000_00000000, 64'hFFFFFFFF_00000005, 64'h00000001_FFFFFFFB,
                            64'h80000000_00000000, 64'hFFFFFFFD_00000001};
    logic [63:0] eu [5] = '{64'h00000000_80000000, 64'hFFFFFFFF_00000005, 64'hFFFFFFFF_FFFFFFFB,
                            64'h80000000_00000000, 64'h00000000_00000007};
    int e, lat; bit f, both, one; logic [63:0] ds, du;
    for (int i = 0; i < 5; i++) begin
      accept_both(ta[i], tb[i], e);
      dvd_valid = 1'b0; dvs_valid = 1'b0;
      collect(f, lat, ds, du, both, one);
      checks++;
      if (!f || ds !== es[i]) begin errors++; $display("FAIL corner_%0d_s: got %h (found=%0b) want %h", i, ds, f, es[i]); end
      checks++;
      if (!f || du !== eu[i]) begin errors++; $display("FAIL corner_%0d_u: got %h (found=%0b) want %h", i, du, f, eu[i]); end
    end
  endtask

  task automatic test_cancel();
    int e, lat, seen; bit f, both, one; logic [63:0] ds, du;
    accept_both(32'd1000, 32'd7, e);
    dvd_valid = 1'b0; dvs_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); cancel = 1'b1; #1;
    checks++;
    if (dvd_ready_s !== 1'b0 || busy_s !== 1'b1) begin
      errors++; $display("FAIL cancel_during: got rdy=%b busy=%b want 0 1", dvd_ready_s, busy_s);
    end
    @(posedge clk); #1; cancel = 1'b0; #1;
    checks++;
    if ({dvd_ready_s, dvs_ready_s, busy_s, dvd_ready_u, busy_u} !== 5'b11010) begin
      errors++; $display("FAIL cancel_after: got %b want 11010", {dvd_ready_s, dvs_ready_s, busy_s, dvd_ready_u, busy_u});
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (dvalid_s || dvalid_u) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL cancel_no_pulse: got %0d pulses want 0", seen); end
    accept_both(32'd9, 32'd3, e);
    dvd_valid = 1'b0; dvs_valid = 1'b0;
    collect(f, lat, ds, du, both, one);
    checks++;
    if (!f || lat != 32 || ds !== 64'h3_00000000 || du !== 64'h3_00000000) begin
      errors++; $display("FAIL cancel_next_op: got lat=%0d s=%h u=%h want 32 0000000300000000", lat, ds, du);
    end
  endtask

  task automatic test_cancel_in_done();
    int e;
    accept_both(32'd50, 32'd5, e);
    dvd_valid = 1'b0; dvs_valid = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    checks++;
    if (dvalid_s !== 1'b1) begin errors++; $display("FAIL done_pulse_present: got %b want 1", dvalid_s); end
    @(negedge clk); cancel = 1'b1; #1;
    checks++;
    if (dvalid_s !== 1'b0 || dvalid_u !== 1'b0) begin
      errors++; $display("FAIL done_cancel_mask: got %b%b want 00", dvalid_s, dvalid_u);
    end
    @(posedge clk); #1; cancel = 1'b0; #1;
    checks++;
    if (dvalid_s !== 1'b0 || dvd_ready_s !== 1'b1) begin
      errors++; $display("FAIL done_cancel_after: got valid=%b rdy=%b want 0 1", dvalid_s, dvd_ready_s);
    end
  endtask

  task automatic test_reset_mid_calc();
    int e, lat; bit f, both, one; logic [63:0] ds, du;
    accept_both(32'd123456789, 32'd1000, e);
    dvd_valid = 1'b0; dvs_valid = 1'b0;
    repeat (15) @(posedge clk);
    #3; resetn = 1'b0; #1;
    checks++;
    if ({dvd_ready_s, dvs_ready_s, dvalid_s, busy_s, dvalid_u, busy_u} !== 6'h00 || dout_s !== 64'h0 || dout_u !== 64'h0) begin
      errors++; $display("FAIL reset_mid: got ctrl=%b s=%h u=%h want 0",
        {dvd_ready_s, dvs_ready_s, dvalid_s, busy_s, dvalid_u, busy_u}, dout_s, dout_u);
    end
    @(negedge clk); resetn = 1'b1;
    accept_both(32'd1, 32'd1, e);
    dvd_valid = 1'b0; dvs_valid = 1'b0;
    collect(f, lat, ds, du, both, one);
    checks++;
    if (!f || ds !== 64'h1_00000000 || du !== 64'h1_00000000) begin
      errors++; $display("FAIL reset_then_op: got s=%h u=%h (found=%0b) want 0000000100000000", ds, du, f);
    end
  endtask

  task automatic test_back_to_back();
    int e, prev, lat; bit f, both, one; logic [63:0] ds, du, xs, xu;
    logic [31:0] a, b;
    prev = -1;
    for (int i = 0; i < 1200; i++) begin
      a = rand_operand(1'b0);
      b = rand_operand(1'b1);
      xs = ref_div(a, b, 1'b1);
      xu = ref_div(a, b, 1'b0);
      accept_both(a, b, e);  // tvalid stays high between operations
      if (prev >= 0) begin
        checks++;
        if (e - prev != 34) begin errors++; $display("FAIL b2b_spacing_%0d: got %0d edges want 34", i, e - prev); end
      end
      prev = e;
      collect(f, lat, ds, du, both, one);
      checks++;
      if (!f || lat != 32) begin errors++; $display("FAIL b2b_latency_%0d: got %0d (found=%0b) want 32", i, lat, f); end
      checks++;
      if (ds !== xs) begin errors++; $display("FAIL b2b_signed_%0d: %h/%h got %h want %h", i, a, b, ds, xs); end
      checks++;
      if (du !== xu) begin errors++; $display("FAIL b2b_unsigned_%0d: %h/%h got %h want %h", i, a, b, du, xu); end
      checks++;
      if (!both || !one) begin errors++; $display("FAIL b2b_pulse_%0d: got both=%0b one=%0b want 1 1", i, both, one); end
    end
    dvd_valid = 1'b0; dvs_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_staggered();
    test_corners();
    test_cancel();
    test_cancel_in_done();
    test_reset_mid_calc();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
